// File: rtl/lsu_port.sv
// Load/store unit port: takes one RV32 load/store request at a time, drives the
// data memory for one access, and returns data or an error code on a response handshake.
module lsu_port #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [6:0]        req_opcode_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic [1:0]        rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [6:0]        mem_opcode_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              mem_data_vld_i
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic [6:0]        opcode_q;
    logic [2:0]        funct3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [CW-1:0]     wait_cnt;
    logic              ready_q;
    logic [DWIDTH-1:0] data_q;
    logic [1:0]        err_q;
    logic [1:0]        req_err;
    logic              in_access;

    // Illegal opcode/funct3 outranks misalignment.
    function automatic logic [1:0] classify(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [1:0] a);
        logic illegal;
        logic misal;
        case (op)
            OP_LOAD:  illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            OP_STORE: illegal = !(f3 inside {3'b000, 3'b001, 3'b010});
            default:  illegal = 1'b1;
        endcase
        misal = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal ? 2'b10 : (misal ? 2'b01 : 2'b00);
    endfunction

    assign req_err = classify(req_opcode_i, req_funct3_i, req_addr_i[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opcode_q <= '0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && ready_q) begin
                        opcode_q <= req_opcode_i;
                        funct3_q <= req_funct3_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        wait_cnt <= '0;
                        data_q   <= '0;
                        err_q    <= req_err;
                        ready_q  <= 1'b0;
                        state    <= (req_err != 2'b00) ? RESP : ACCESS;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (opcode_q == OP_STORE) begin
                        state <= RESP;
                    end else if (mem_data_vld_i) begin
                        data_q <= mem_data_i;
                        state  <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err_q <= 2'b11;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    // ready rises only after the consuming cycle, so no back-to-back accept
                    if (rsp_ready_i) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_access      = (state == ACCESS);
    assign req_ready_o    = ready_q;
    assign rsp_valid_o    = (state == RESP);
    assign rsp_data_o     = data_q;
    assign rsp_err_o      = err_q;
    assign mem_addr_o     = in_access ? addr_q   : '0;
    assign mem_data_o     = in_access ? wdata_q  : '0;
    assign mem_opcode_o   = in_access ? opcode_q : '0;
    assign mem_funct3_o   = in_access ? funct3_q : '0;
    assign mem_read_en_o  = in_access && (opcode_q == OP_LOAD);
    assign mem_write_en_o = in_access && (opcode_q == OP_STORE);

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them on every response handshake.
module tb_lsu_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [6:0]  req_opcode_i = '0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [6:0]  mem_opcode_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_data_i = '0;
    logic        mem_data_vld_i = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    lsu_port #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opcode_i(req_opcode_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_opcode_o(mem_opcode_o), .mem_funct3_o(mem_funct3_o),
        .mem_data_i(mem_data_i), .mem_data_vld_i(mem_data_vld_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: compares on each handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            logic [33:0] e;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rsp_err_o, rsp_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data_o), 64'(e[31:0]));
                chk("rsp_err", 64'(rsp_err_o), 64'(e[33:32]));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!req_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = req_ready_o;
        if (!ok) chk("ready_timeout", 64'(req_ready_o), 64'd1);
    endtask

    task automatic issue(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int vld_delay,
                         input logic [31:0] exp_data, input logic [1:0] exp_err,
                         input int exp_lat, input int exp_rd, input int exp_wr, input int stall);
        bit ok;
        int lat, rd, wr;
        logic [31:0] d0;
        logic [1:0]  e0;
        wait_ready(ok);
        if (!ok) return;
        req_valid_i = 1'b1; req_opcode_i = op; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wdata;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_opcode_i = 7'h7F; req_funct3_i = 3'b111;
        req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'h5555_AAAA;
        lat = 1; rd = 0; wr = 0;
        while (!rsp_valid_o && lat < 40) begin
            if (mem_read_en_o) begin
                if (vld_delay >= 0 && rd == vld_delay) begin
                    mem_data_vld_i = 1'b1; mem_data_i = rdata;
                end
                chk({name, "_raddr"}, 64'(mem_addr_o), 64'(addr));
                rd++;
            end
            if (mem_write_en_o) begin
                chk({name, "_waddr"}, 64'(mem_addr_o), 64'(addr));
                chk({name, "_wdata"}, 64'(mem_data_o), 64'(wdata));
                chk({name, "_wf3"}, 64'(mem_funct3_o), 64'(f3));
                mem_data_vld_i = 1'b1; mem_data_i = 32'hBAD0_BAD0;
                wr++;
            end
            @(posedge clk); #1;
            mem_data_vld_i = 1'b0; mem_data_i = '0;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_rd_cycles"}, 64'(rd), 64'(exp_rd));
        chk({name, "_wr_cycles"}, 64'(wr), 64'(exp_wr));
        chk({name, "_mem_idle"}, {mem_addr_o, mem_data_o}, 64'd0);
        d0 = rsp_data_o; e0 = rsp_err_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({name, "_stall_valid"}, 64'(rsp_valid_o), 64'd1);
            chk({name, "_stall_data"}, {30'd0, rsp_err_o, rsp_data_o}, {30'd0, e0, d0});
            chk({name, "_stall_ready"}, 64'(req_ready_o), 64'd0);
        end
        chk({name, "_ready_in_resp"}, 64'(req_ready_o), 64'd0);
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        chk({name, "_ready_after"}, {62'd0, rsp_valid_o, req_ready_o}, 64'd1);
    endtask

    initial begin
        bit ok;
        #2;
        chk("reset_ready", 64'(req_ready_o), 64'd0);
        chk("reset_rsp", {29'd0, rsp_valid_o, rsp_err_o, rsp_data_o}, 64'd0);
        chk("reset_mem", {mem_addr_o, mem_data_o}, 64'd0);
        chk("reset_en", {54'd0, mem_read_en_o, mem_write_en_o, mem_opcode_o, 1'b0}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue("sw", STORE, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0, 0,
              32'h0, 2'b00, 2, 0, 1, 0);
        issue("lb", LOAD, 3'b000, 32'h0100_0003, 32'h0, 32'hFFFF_FF80, 0,
              32'hFFFF_FF80, 2'b00, 2, 1, 0, 0);
        issue("lw_misal", LOAD, 3'b010, 32'h0100_0002, 32'h0, 32'h1234_5678, 0,
              32'h0, 2'b01, 1, 0, 0, 0);
        issue("bad_op", 7'b0110011, 3'b010, 32'h0100_0000, 32'h0, 32'h0, 0,
              32'h0, 2'b10, 1, 0, 0, 0);
        issue("timeout", LOAD, 3'b010, 32'h0100_0020, 32'h0, 32'h0, -1,
              32'h0, 2'b11, 9, 8, 0, 0);
        issue("lhu_stall", LOAD, 3'b101, 32'h0100_0006, 32'h0, 32'h0000_1234, 2,
              32'h0000_1234, 2'b00, 4, 3, 0, 5);
        issue("sbu_illegal", STORE, 3'b100, 32'h0100_0000, 32'h11, 32'h0, 0,
              32'h0, 2'b10, 1, 0, 0, 0);
        issue("ld_prio", LOAD, 3'b011, 32'h0100_0001, 32'h0, 32'h0, 0,
              32'h0, 2'b10, 1, 0, 0, 0);
        issue("sh_misal", STORE, 3'b001, 32'h0100_0005, 32'hAB, 32'h0, 0,
              32'h0, 2'b01, 1, 0, 0, 0);

        // Reset in the middle of a load that never gets data.
        wait_ready(ok);
        req_valid_i = 1'b1; req_opcode_i = LOAD; req_funct3_i = 3'b010;
        req_addr_i = 32'h0100_0100;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_pre_rd", 64'(mem_read_en_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_rd_drop", 64'(mem_read_en_o), 64'd0);
        chk("rst_outs", {61'd0, rsp_valid_o, req_ready_o, mem_write_en_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
        end
        issue("lw_after_rst", LOAD, 3'b010, 32'h0100_0104, 32'h0, 32'hCAFE_F00D, 1,
              32'hCAFE_F00D, 2'b00, 3, 2, 0, 0);

        repeat (2) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
